// File: rtl/psram_qspi_master_if.sv
// Host-side request/response bus of psram_qspi_master.
// The host drives the master modport and the controller uses the slave modport.
interface psram_qspi_master_if;
   logic        start;
   logic        wr;
   logic [23:0] addr;
   logic [1:0]  size;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        busy;
   logic        done;

   modport master (output start, wr, addr, size, wdata, input  rdata, busy, done);
   modport slave  (input  start, wr, addr, size, wdata, output rdata, busy, done);
endinterface

// File: rtl/psram_qspi_master.sv
// Quad-SPI PSRAM master: one 1..4 byte quad write (0x38) or quad fast read (0xEB)
// per request. sck runs at clk/2, and the pins are decoded from state, counter and phase.
module psram_qspi_master (
   input  logic                      clk,
   input  logic                      rst_n,
   psram_qspi_master_if.slave        bus,
   output logic                      o_sck,
   output logic                      o_ce_n,
   output logic [3:0]                o_dout,
   output logic [3:0]                o_douten,
   input  logic [3:0]                i_din
);
   typedef enum logic [2:0] {S_IDLE, S_CMD, S_ADDR, S_DUMMY, S_DATA, S_DONE} state_t;

   state_t      r_state, w_state_nxt;
   logic        r_ph, w_ph_nxt;
   logic [2:0]  r_cnt, w_cnt_nxt;
   logic        r_wr;
   logic [23:0] r_addr;
   logic [1:0]  r_size;
   logic [31:0] r_wdata;
   logic [31:0] r_rbuf;
   logic [31:0] r_rdata;

   logic        w_active;
   logic [2:0]  w_cnt_max;
   logic [7:0]  w_cmd;
   logic [4:0]  w_nib_sel;
   logic [4:0]  w_addr_sel;

   assign w_active   = (r_state == S_CMD) || (r_state == S_ADDR) ||
                       (r_state == S_DUMMY) || (r_state == S_DATA);
   assign w_cmd      = r_wr ? 8'h38 : 8'hEB;
   // Data nibble k: byte k/2, high nibble on even k
   assign w_nib_sel  = {r_cnt[2:1], ~r_cnt[0], 2'b00};
   assign w_addr_sel = {3'd5 - r_cnt, 2'b00};

   always_comb begin
      w_cnt_max = '0;
      case (r_state)
         S_CMD:   w_cnt_max = 3'd7;
         S_ADDR:  w_cnt_max = 3'd5;
         S_DUMMY: w_cnt_max = 3'd5;
         S_DATA:  w_cnt_max = {r_size, 1'b1};
         default: w_cnt_max = '0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_ph    <= 1'b0;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_ph    <= w_ph_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // A phase advances on the edge that ends the sck-high half of its last cycle
   always_comb begin
      w_state_nxt = r_state;
      w_ph_nxt    = 1'b0;
      w_cnt_nxt   = r_cnt;
      case (r_state)
         S_IDLE: begin
            if (bus.start) begin
               w_state_nxt = S_CMD;
               w_cnt_nxt   = '0;
            end
         end
         S_DONE: w_state_nxt = S_IDLE;
         default: begin
            w_ph_nxt = ~r_ph;
            if (r_ph) begin
               w_cnt_nxt = r_cnt + 3'd1;
               if (r_cnt == w_cnt_max) begin
                  w_cnt_nxt = '0;
                  case (r_state)
                     S_CMD:   w_state_nxt = S_ADDR;
                     S_ADDR:  w_state_nxt = r_wr ? S_DATA : S_DUMMY;
                     S_DUMMY: w_state_nxt = S_DATA;
                     default: w_state_nxt = S_DONE;
                  endcase
               end
            end
         end
      endcase
   end

   always_comb begin
      o_dout   = '0;
      o_douten = '0;
      case (r_state)
         S_CMD: begin
            o_douten  = 4'b0001;
            o_dout[0] = w_cmd[3'd7 - r_cnt];
         end
         S_ADDR: begin
            o_douten = 4'b1111;
            o_dout   = r_addr[w_addr_sel +: 4];
         end
         S_DATA: begin
            if (r_wr) begin
               o_douten = 4'b1111;
               o_dout   = r_wdata[w_nib_sel +: 4];
            end
         end
         default: ;
      endcase
   end

   assign o_sck      = r_ph;
   assign o_ce_n     = ~w_active;
   assign bus.busy   = w_active;
   assign bus.done   = (r_state == S_DONE);
   assign bus.rdata  = r_rdata;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr    <= 1'b0;
         r_addr  <= '0;
         r_size  <= '0;
         r_wdata <= '0;
         r_rbuf  <= '0;
         r_rdata <= '0;
      end else begin
         if (r_state == S_IDLE && bus.start) begin
            r_wr    <= bus.wr;
            r_addr  <= bus.addr;
            r_size  <= bus.size;
            r_wdata <= bus.wdata;
            r_rbuf  <= '0;
         end
         if (r_state == S_DATA && !r_wr && !r_ph)
            r_rbuf[w_nib_sel +: 4] <= i_din;
         // rbuf already holds the final nibble when the last high phase ends
         if (r_state == S_DATA && !r_wr && r_ph && r_cnt == w_cnt_max)
            r_rdata <= r_rbuf;
      end
   end
endmodule

// File: tb/tb_psram_qspi_master.sv
// Randomized bench for psram_qspi_master: a pin-level PSRAM device model plus a
// byte-array reference memory that predicts pin streams and read data.
module tb_psram_qspi_master;
   logic       clk = 1'b0;
   logic       rst_n;
   logic       w_sck, w_ce_n;
   logic [3:0] w_dout, w_douten;
   logic [3:0] r_din = '0;

   psram_qspi_master_if bus_if();

   psram_qspi_master dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .bus      (bus_if.slave),
      .o_sck    (w_sck),
      .o_ce_n   (w_ce_n),
      .o_dout   (w_dout),
      .o_douten (w_douten),
      .i_din    (r_din)
   );

   always #5 clk = ~clk;

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;
   logic [7:0]  dev_mem [0:255];
   logic [7:0]  ref_mem [0:255];
   logic [3:0]  tr_d  [$];
   logic [3:0]  tr_oe [$];
   int unsigned n_ce_fall = 0;
   time         t_rise = 0;
   time         last_gap = 0;
   logic [31:0] exp_rdata = '0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // PSRAM device: decodes the pins at each sck rise, stores writes, serves reads
   initial begin
      logic [7:0]  cmd;
      logic [23:0] a;
      logic [3:0]  hi;
      logic [7:0]  b, idx;
      int          n, k;
      forever begin
         @(negedge w_ce_n);
         if (t_rise != 0) last_gap = $time - t_rise;
         n_ce_fall++;
         n = 0; cmd = '0; a = '0; hi = '0;
         while (w_ce_n === 1'b0) begin
            @(posedge w_sck or posedge w_ce_n);
            if (w_ce_n === 1'b1) break;
            #1;
            tr_d.push_back(w_dout);
            tr_oe.push_back(w_douten);
            if (n < 8) cmd = {cmd[6:0], w_dout[0]};
            else if (n < 14) a = {a[19:0], w_dout};
            else if (cmd == 8'h38) begin
               k = n - 14;
               idx = a[7:0] + 8'(k / 2);
               if (k % 2 == 0) hi = w_dout;
               else dev_mem[idx] = {hi, w_dout};
            end
            if (cmd == 8'hEB && n >= 19) begin
               k = n - 19;
               idx = a[7:0] + 8'(k / 2);
               b = dev_mem[idx];
               r_din = (k % 2 == 0) ? b[7:4] : b[3:0];
            end
            n++;
         end
         t_rise = $time;
      end
   end

   task automatic do_txn(input logic w, input logic [23:0] a, input logic [1:0] s,
                         input logic [31:0] wd, input bit poke);
      logic [3:0]  e_d  [$];
      logic [3:0]  e_oe [$];
      logic [7:0]  cmd, byt;
      logic [31:0] e_rd;
      logic [3:0]  got_d;
      int unsigned nb, cnt, ce0, nchk;
      bit          got_done;
      nb  = int'(s) + 1;
      cmd = w ? 8'h38 : 8'hEB;
      e_rd = '0;
      for (int i = 0; i < 8; i++) begin
         e_oe.push_back(4'b0001);
         e_d.push_back({3'b000, cmd[7-i]});
      end
      for (int i = 0; i < 6; i++) begin
         e_oe.push_back(4'b1111);
         e_d.push_back(a[23-4*i -: 4]);
      end
      if (!w) for (int i = 0; i < 6; i++) begin
         e_oe.push_back(4'b0000);
         e_d.push_back(4'h0);
      end
      for (int j = 0; j < int'(nb); j++) begin
         byt = w ? wd[8*j +: 8] : ref_mem[a[7:0] + 8'(j)];
         e_rd[8*j +: 8] = byt;
         e_oe.push_back(w ? 4'b1111 : 4'b0000);
         e_d.push_back(w ? byt[7:4] : 4'h0);
         e_oe.push_back(w ? 4'b1111 : 4'b0000);
         e_d.push_back(w ? byt[3:0] : 4'h0);
      end

      tr_d.delete(); tr_oe.delete();
      ce0 = n_ce_fall;
      bus_if.start = 1'b1; bus_if.wr = w; bus_if.addr = a; bus_if.size = s; bus_if.wdata = wd;
      @(negedge clk);
      bus_if.start = 1'b0; bus_if.wr = ~w; bus_if.addr = 24'($urandom);
      bus_if.size = ~s; bus_if.wdata = $urandom;
      chk("busy_after_start", 32'(bus_if.busy), 32'd1);
      chk("ce_n_low", 32'(w_ce_n), 32'd0);
      chk("sck_first_low", 32'(w_sck), 32'd0);

      got_done = 1'b0; cnt = 0;
      while (!got_done && cnt < 200) begin
         bus_if.start = (poke && cnt == 4);
         @(negedge clk);
         cnt++;
         got_done = (bus_if.done === 1'b1);
      end
      bus_if.start = 1'b0;
      chk("done_seen", 32'(got_done), 32'd1);
      chk("busy_at_done", 32'(bus_if.busy), 32'd0);
      chk("ce_n_at_done", 32'(w_ce_n), 32'd1);
      chk("sck_at_done", 32'(w_sck), 32'd0);
      chk("sck_cycles", 32'(tr_d.size()), 32'(e_d.size()));
      nchk = (tr_d.size() < e_d.size()) ? tr_d.size() : e_d.size();
      for (int i = 0; i < int'(nchk); i++) begin
         got_d = (e_oe[i] == 4'b0000) ? 4'h0 : tr_d[i];
         chk("pin_oe_data", 32'({tr_oe[i], got_d}), 32'({e_oe[i], e_d[i]}));
      end
      if (!w) exp_rdata = e_rd;
      chk(w ? "rdata_held" : "rdata", bus_if.rdata, exp_rdata);
      if (w) for (int j = 0; j < int'(nb); j++) ref_mem[a[7:0] + 8'(j)] = wd[8*j +: 8];
      @(negedge clk);
      chk("done_one_cycle", 32'(bus_if.done), 32'd0);
      chk("one_txn_on_pins", n_ce_fall - ce0, 32'd1);
   endtask

   initial begin
      for (int i = 0; i < 256; i++) begin
         dev_mem[i] = '0;
         ref_mem[i] = '0;
      end
      bus_if.start = 1'b0; bus_if.wr = 1'b0; bus_if.addr = '0;
      bus_if.size = '0; bus_if.wdata = '0;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_ce_n", 32'(w_ce_n), 32'd1);
      chk("rst_sck", 32'(w_sck), 32'd0);
      chk("rst_douten", 32'(w_douten), 32'd0);
      chk("rst_dout", 32'(w_dout), 32'd0);
      chk("rst_busy", 32'(bus_if.busy), 32'd0);
      chk("rst_done", 32'(bus_if.done), 32'd0);
      chk("rst_rdata", bus_if.rdata, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      do_txn(1'b1, 24'h000010, 2'd3, 32'hDDCCBBAA, 1'b0);
      do_txn(1'b0, 24'h000010, 2'd3, 32'h0, 1'b0);
      chk("read4_const", bus_if.rdata, 32'hDDCCBBAA);
      chk("b2b_ce_gap_ge2", 32'(last_gap >= 20), 32'd1);
      do_txn(1'b0, 24'h000012, 2'd0, 32'h0, 1'b0);
      chk("read1_const", bus_if.rdata, 32'h000000CC);
      do_txn(1'b1, 24'h000040, 2'd1, 32'h12345678, 1'b1);
      do_txn(1'b0, 24'h000040, 2'd2, 32'h0, 1'b1);

      // Abort a write while the address is on the pins
      bus_if.start = 1'b1; bus_if.wr = 1'b1; bus_if.addr = 24'h000010;
      bus_if.size = 2'd3; bus_if.wdata = 32'h99887766;
      @(negedge clk);
      bus_if.start = 1'b0;
      repeat (19) @(negedge clk);
      chk("in_addr_douten", 32'(w_douten), 32'hF);
      #2 rst_n = 1'b0;
      #1;
      chk("abort_ce_n", 32'(w_ce_n), 32'd1);
      chk("abort_sck", 32'(w_sck), 32'd0);
      chk("abort_douten", 32'(w_douten), 32'd0);
      chk("abort_busy", 32'(bus_if.busy), 32'd0);
      chk("abort_rdata", bus_if.rdata, 32'd0);
      exp_rdata = '0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("abort_no_done", 32'(bus_if.done), 32'd0);
      end
      rst_n = 1'b1;
      @(negedge clk);
      do_txn(1'b0, 24'h000010, 2'd3, 32'h0, 1'b0);
      chk("after_abort_const", bus_if.rdata, 32'hDDCCBBAA);

      for (int t = 0; t < 20; t++)
         do_txn(1'($urandom), 24'($urandom_range(0, 63)), 2'($urandom), $urandom,
                1'($urandom_range(0, 3) == 0));

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule
